// File: rtl/dval_to_rdy_fifo.sv
// Push-only result stream to valid/ready adapter: small FWFT FIFO that drops,
// flags and counts words arriving while it is full.
module dval_to_rdy_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_dval,
    input  logic [DW-1:0] i,
    input  logic          clr,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          pop;
    logic          push;
    logic          drop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign o_valid = ~empty;
    assign o       = mem[rd_ptr];

    // A pop frees the slot the same cycle, so a full FIFO still accepts a word.
    assign pop  = o_valid & o_ready;
    assign push = i_dval & (~full | pop);
    assign drop = i_dval & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // A drop in the same cycle as clr counts as the first drop after the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_dval_to_rdy_fifo.sv
// Self-checking bench for dval_to_rdy_fifo: directed vector table, async reset
// sequence, and random traffic against a queue-based reference model.
module tb_dval_to_rdy_fifo;
    localparam int DW    = 10;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_dval;
    logic [DW-1:0] i;
    logic          clr;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [7:0]    drop_cnt;

    dval_to_rdy_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_dval   (i_dval),
        .i        (i),
        .clr      (clr),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o        (o),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: queue of buffered words plus drop bookkeeping
    int q[$];
    int m_drops;
    bit m_ovf;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void compare_model();
        check("count", int'(count), q.size());
        check("o_valid", int'(o_valid), int'(q.size() > 0));
        check("full", int'(full), int'(q.size() == DEPTH));
        check("empty", int'(empty), int'(q.size() == 0));
        check("overflow", int'(overflow), int'(m_ovf));
        check("drop_cnt", int'(drop_cnt), m_drops);
        if (q.size() > 0) check("o", int'(o), q[0]);
    endfunction

    // Called 1 time unit after a rising edge; applies inputs for one cycle.
    task automatic step(input logic dv, input logic [DW-1:0] d, input logic rdy, input logic c);
        bit m_pop, m_push, m_drop;
        i_dval  = dv;
        i       = d;
        o_ready = rdy;
        clr     = c;
        m_pop  = (q.size() > 0) && rdy;
        m_push = dv && ((q.size() < DEPTH) || m_pop);
        m_drop = dv && !m_push;
        @(posedge clk);
        #1;
        if (m_pop)  void'(q.pop_front());
        if (m_push) q.push_back(int'(d));
        if (c) begin
            m_ovf   = 0;
            m_drops = 0;
        end
        if (m_drop) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
        end
        compare_model();
    endtask

    typedef struct {
        logic          dv;
        logic [DW-1:0] d;
        logic          rdy;
        logic          c;
        logic          ev;
        int            eo;
        int            ec;
        logic          eovf;
        int            edrop;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // ordering with o_ready=1: count never exceeds 1
        tbl.push_back('{1, 10, 1, 0, 1, 10, 1, 0, 0});
        tbl.push_back('{1, 20, 1, 0, 1, 20, 1, 0, 0});
        tbl.push_back('{1, 30, 1, 0, 1, 30, 1, 0, 0});
        tbl.push_back('{0,  0, 1, 0, 0,  0, 0, 0, 0});
        // fill and stall, then one drop
        tbl.push_back('{1,  1, 0, 0, 1,  1, 1, 0, 0});
        tbl.push_back('{1,  2, 0, 0, 1,  1, 2, 0, 0});
        tbl.push_back('{1,  3, 0, 0, 1,  1, 3, 0, 0});
        tbl.push_back('{1,  4, 0, 0, 1,  1, 4, 0, 0});
        tbl.push_back('{1,  5, 0, 0, 1,  1, 4, 1, 1});
        // full with simultaneous pop: 9 accepted, no drop
        tbl.push_back('{1,  9, 1, 0, 1,  2, 4, 1, 1});
        tbl.push_back('{0,  0, 1, 0, 1,  3, 3, 1, 1});
        tbl.push_back('{0,  0, 1, 0, 1,  4, 2, 1, 1});
        tbl.push_back('{0,  0, 1, 0, 1,  9, 1, 1, 1});
        tbl.push_back('{0,  0, 1, 0, 0,  0, 0, 1, 1});
        // refill for saturation test
        tbl.push_back('{1, 11, 0, 0, 1, 11, 1, 1, 1});
        tbl.push_back('{1, 12, 0, 0, 1, 11, 2, 1, 1});
        tbl.push_back('{1, 13, 0, 0, 1, 11, 3, 1, 1});
        tbl.push_back('{1, 14, 0, 0, 1, 11, 4, 1, 1});

        rst = 1'b1; i_dval = 1'b0; i = '0; clr = 1'b0; o_ready = 1'b0;
        q.delete(); m_drops = 0; m_ovf = 0;
        #12;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            step(tbl[k].dv, tbl[k].d, tbl[k].rdy, tbl[k].c);
            check($sformatf("vec%0d_o_valid", k), int'(o_valid), int'(tbl[k].ev));
            if (tbl[k].ev) check($sformatf("vec%0d_o", k), int'(o), tbl[k].eo);
            check($sformatf("vec%0d_count", k), int'(count), tbl[k].ec);
            check($sformatf("vec%0d_full", k), int'(full), int'(tbl[k].ec == DEPTH));
            check($sformatf("vec%0d_overflow", k), int'(overflow), int'(tbl[k].eovf));
            check($sformatf("vec%0d_drop_cnt", k), int'(drop_cnt), tbl[k].edrop);
        end

        // saturation of drop_cnt
        for (int n = 0; n < 300; n++) step(1'b1, DW'(n), 1'b0, 1'b0);
        check("sat_drop_cnt", int'(drop_cnt), 255);
        check("sat_count", int'(count), 4);
        check("sat_head", int'(o), 11);

        step(1'b0, '0, 1'b0, 1'b1);
        check("clr_overflow", int'(overflow), 0);
        check("clr_drop_cnt", int'(drop_cnt), 0);
        check("clr_count", int'(count), 4);

        step(1'b1, 10'd7, 1'b0, 1'b1);
        check("clr_drop_overflow", int'(overflow), 1);
        check("clr_drop_drop_cnt", int'(drop_cnt), 1);

        step(1'b0, '0, 1'b1, 1'b0);
        check("pre_rst_count", int'(count), 3);

        // asynchronous reset between edges
        i_dval = 1'b0; o_ready = 1'b0; clr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_o_valid", int'(o_valid), 0);
        check("async_rst_overflow", int'(overflow), 0);
        check("async_rst_drop_cnt", int'(drop_cnt), 0);
        check("async_rst_empty", int'(empty), 1);
        q.delete(); m_drops = 0; m_ovf = 0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare_model();

        // first write right after release, latency of one cycle
        step(1'b1, 10'd77, 1'b0, 1'b0);
        check("post_rst_o", int'(o), 77);
        step(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int n = 0; n < 10000; n++) begin
            step($urandom_range(0, 99) < 70, DW'($urandom_range(0, 1023)),
                 $urandom_range(0, 99) < 50, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dval_to_rdy_fifo.md
Name: dval_to_rdy_fifo

Overview:
- Downstream stage of the sum-every-3 DUT. It converts that block's push-only result stream (i_dval/i, no backpressure) into a valid/ready stream for consumers that can stall.
- It buffers results in a small first-word-fall-through FIFO.
- It reports overflow: a result arriving when no slot is free is dropped, flagged and counted, and never silently corrupts buffered data.

Parameters:
- DW, 10, data width of each result word.
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.
- CW, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- i_dval  in  1  input word valid; no backpressure exists upstream.
- i  in  DW  input word, sampled when i_dval=1.
- clr  in  1  synchronous pulse; clears overflow and drop_cnt only (FIFO contents kept).
- o_valid  out  1  head word available.
- o_ready  in  1  consumer accepts head this cycle.
- o  out  DW  head word (FWFT); value is don't-care when o_valid=0.
- count  out  CW  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky: at least one input dropped since rst/clr.
- drop_cnt  out  8  number of dropped inputs, saturating at 255.

Behaviour:
- Reset (async assert, any time): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, o_valid=0, overflow=0, drop_cnt=0. Storage contents are not reset. Release is synchronous to clk; first write is possible on the first posedge with rst=0.
- Storage: DEPTH x DW register array, with log2(DEPTH)-bit read and write pointers. Pointers wrap naturally from DEPTH-1 to 0. count is held explicitly.
- pop = o_valid & o_ready.
- push = i_dval & (~full | pop).
  - A write into a full FIFO is accepted when a pop occurs in the same cycle.
- drop = i_dval & full & ~pop.
- On push: mem[wr_ptr] <= i, and wr_ptr increments.
- On pop: rd_ptr increments.
- Count update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - both or neither: count unchanged.
- o = mem[rd_ptr] (combinational read of registered storage). o_valid = ~empty.
- No empty bypass: a word pushed at edge N first appears with o_valid=1 in the cycle after edge N. Minimum latency i_dval to o_valid is 1 cycle.
- Simultaneous push and pop when count==1: the old head is consumed and the new word becomes head next cycle; count stays 1.
- o_ready while o_valid=0 has no effect.
- o and o_valid are stable while o_valid=1 and o_ready=0 (standard valid/ready hold).
- Drop handling: on a drop, overflow <= 1, and drop_cnt <= drop_cnt + 1 unless it is 255.
- clr: overflow and drop_cnt are cleared. If clr and drop occur in the same cycle, the result is overflow=1, drop_cnt=1 (the drop wins over clr).
- full, empty and count are registered-derived, with no combinational path from i_dval.
- The only combinational input-to-output path is rd_ptr to o. o_ready does not affect o_valid in the same cycle.

Test Plan:
- Reset mid-operation: fill 3 words, assert rst asynchronously between edges -> count, o_valid and overflow go to 0 immediately, without waiting for a clock edge.
- Basic ordering: with o_ready=1, push 10,20,30 on consecutive cycles -> o_valid high from the cycle after the first push; o shows 10,20,30 in order; count never exceeds 1.
- Fill and stall: o_ready=0, push 1,2,3,4 (DEPTH=4) -> full=1, count=4. A 5th push of 5 -> dropped: overflow=1, drop_cnt=1. Then drain with o_ready=1 -> exactly 1,2,3,4 out, then empty=1.
- Full with simultaneous pop: full with head 1, i_dval=1 (value 9) and o_ready=1 in the same cycle -> no drop, count stays 4; the drained order ends ...,4,9.
- Saturation and clr: hold full with o_ready=0 and drive 300 dropped inputs -> drop_cnt=255. Pulse clr -> overflow=0, drop_cnt=0, count still 4. clr together with a drop -> drop_cnt=1, overflow=1.
- Random: random i_dval/o_ready at 70%/50% for 10k cycles against a scoreboard queue -> output sequence equals accepted inputs, and drop_cnt equals the model's drop count (saturated).
